pc_sequencer: RTL and testbench

//   Owns and sequences the 32-bit program counter for the 5-stage pipeline.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_target_sel.sv | 32 +++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and default constants for the PC sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH,
    ST_HALT
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_JMP,
    SRC_BR,
    SRC_EXC
  } redir_src_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0400;

endpackage

// File: rtl/pc_target_sel.sv
// rtl/pc_target_sel.sv - priority select of next PC and redirect source
module pc_target_sel
  import pc_seq_pkg::*;
(
  input  logic        exc,
  input  logic [31:0] exc_target,
  input  logic        br,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic [31:0] pc_plus1,
  output logic [31:0] next_pc,
  output redir_src_e  src
);

  // Older instruction wins: exception, then execute-stage branch, then decode jump.
  always_comb begin
    next_pc = pc_plus1;
    src     = SRC_NONE;
    if (exc) begin
      next_pc = exc_target;
      src     = SRC_EXC;
    end else if (br) begin
      next_pc = br_target;
      src     = SRC_BR;
    end else if (jmp) begin
      next_pc = jmp_target;
      src     = SRC_JMP;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter FSM with stall, redirect buffering and flush window
// Optional exception support (exc/epc ports) is built when PC_EXCEPTION_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
`ifdef PC_EXCEPTION_EN
  input  logic        exc,
  output logic [31:0] epc,
`endif
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus1,
  output logic        fetch_valid,
  output logic        flush
);

  pc_state_e   state;
  logic [1:0]  cnt;
  logic        pend_valid;
  logic        pend_is_br;
  logic [31:0] pend_target;
  logic        exc_req;
  logic        eff_br;
  logic        eff_jmp;
  logic [31:0] eff_br_target;
  logic [31:0] eff_jmp_target;
  logic [31:0] sel_pc;
  redir_src_e  sel_src;
  logic        hold_redirect;

`ifdef PC_EXCEPTION_EN
  assign exc_req = exc;
`else
  assign exc_req = 1'b0;
`endif

  assign pc_plus1 = pc_out + 32'd1;

  // A buffered redirect is merged with live requests so both go through one priority select.
  assign eff_br         = br_taken | (pend_valid & pend_is_br);
  assign eff_br_target  = br_taken ? br_target : pend_target;
  assign eff_jmp        = jmp_valid | (pend_valid & ~pend_is_br);
  assign eff_jmp_target = jmp_valid ? jmp_target : pend_target;

  pc_target_sel u_sel (
    .exc        (exc_req),
    .exc_target (EXC_VECTOR),
    .br         (eff_br),
    .br_target  (eff_br_target),
    .jmp        (eff_jmp),
    .jmp_target (eff_jmp_target),
    .pc_plus1   (pc_plus1),
    .next_pc    (sel_pc),
    .src        (sel_src)
  );

  assign hold_redirect = (state == ST_STALL) && stall && (sel_src != SRC_EXC);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out      <= RESET_PC;
      state       <= ST_RUN;
      flush       <= 1'b0;
      fetch_valid <= 1'b0;
      cnt         <= 2'd0;
      pend_valid  <= 1'b0;
      pend_is_br  <= 1'b0;
      pend_target <= 32'd0;
`ifdef PC_EXCEPTION_EN
      epc         <= 32'd0;
`endif
    end else if (state != ST_HALT) begin
      if (sel_src != SRC_NONE && !hold_redirect) begin
        pc_out      <= sel_pc;
        state       <= ST_FLUSH;
        cnt         <= 2'(FLUSH_CYCLES);
        flush       <= 1'b1;
        fetch_valid <= 1'b1;
        pend_valid  <= 1'b0;
`ifdef PC_EXCEPTION_EN
        if (sel_src == SRC_EXC) epc <= pc_out;
`endif
      end else begin
        case (state)
          ST_RUN: begin
            if (halt) begin
              state       <= ST_HALT;
              fetch_valid <= 1'b0;
            end else if (stall) begin
              state       <= ST_STALL;
              fetch_valid <= 1'b0;
            end else if (fetch_valid) begin
              pc_out <= pc_plus1;
            end else begin
              // First cycle after reset fetches RESET_PC itself.
              fetch_valid <= 1'b1;
            end
          end
          ST_STALL: begin
            if (stall) begin
              if (br_taken) begin
                pend_valid  <= 1'b1;
                pend_is_br  <= 1'b1;
                pend_target <= br_target;
              end else if (jmp_valid && !(pend_valid && pend_is_br)) begin
                pend_valid  <= 1'b1;
                pend_is_br  <= 1'b0;
                pend_target <= jmp_target;
              end
            end else begin
              state       <= ST_RUN;
              fetch_valid <= 1'b1;
            end
          end
          ST_FLUSH: begin
            if (halt) begin
              state       <= ST_HALT;
              flush       <= 1'b0;
              fetch_valid <= 1'b0;
            end else if (!stall) begin
              pc_out <= pc_plus1;
              if (cnt == 2'd1) begin
                state <= ST_RUN;
                flush <= 1'b0;
              end else begin
                cnt <= cnt - 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_target = 32'd0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus1;
  logic        fetch_valid;
  logic        flush;
`ifdef PC_EXCEPTION_EN
  logic        exc = 1'b0;
  logic [31:0] epc;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .halt        (halt),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
`ifdef PC_EXCEPTION_EN
    .exc         (exc),
    .epc         (epc),
`endif
    .pc_out      (pc_out),
    .pc_plus1    (pc_plus1),
    .fetch_valid (fetch_valid),
    .flush       (flush)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_pf(input string tag, input logic [31:0] p, input logic f);
    check({tag, "_pc"}, pc_out, p);
    check({tag, "_flush"}, {31'd0, flush}, {31'd0, f});
  endtask

  initial begin
    // reset then idle: 0,0,1,2,3
    step();
    check_pf("rst", 32'd0, 1'b0);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    reset = 1'b0;
    step();
    check_pf("idle0", 32'd0, 1'b0);
    check("idle0_fv", {31'd0, fetch_valid}, 32'd1);
    step(); check_pf("idle1", 32'd1, 1'b0);
    step(); check_pf("idle2", 32'd2, 1'b0);
    step(); check_pf("idle3", 32'd3, 1'b0);
    step(); step();
    check_pf("pc5", 32'd5, 1'b0);

    // branch at pc=5
    br_taken = 1'b1; br_target = 32'h40;
    step(); check_pf("br0", 32'h40, 1'b1);
    br_taken = 1'b0;
    step(); check_pf("br1", 32'h41, 1'b1);
    step(); check_pf("br2", 32'h42, 1'b0);

    // branch beats jump
    br_taken = 1'b1; br_target = 32'h80; jmp_valid = 1'b1; jmp_target = 32'h90;
    step(); check_pf("brjmp0", 32'h80, 1'b1);
    br_taken = 1'b0; jmp_valid = 1'b0;
    step(); check_pf("brjmp1", 32'h81, 1'b1);
    step(); check_pf("brjmp2", 32'h82, 1'b0);

    // stall 3 cycles, jump arrives in second stall cycle
    stall = 1'b1;
    step(); check_pf("st1", 32'h82, 1'b0);
    check("st1_fv", {31'd0, fetch_valid}, 32'd0);
    jmp_valid = 1'b1; jmp_target = 32'h20;
    step(); check_pf("st2", 32'h82, 1'b0);
    jmp_valid = 1'b0;
    step(); check_pf("st3", 32'h82, 1'b0);
    stall = 1'b0;
    step(); check_pf("st_apply", 32'h20, 1'b1);
    check("st_apply_fv", {31'd0, fetch_valid}, 32'd1);
    step(); check_pf("st_f1", 32'h21, 1'b1);
    step(); check_pf("st_f2", 32'h22, 1'b0);

    // pending branch is not overwritten by a later jump
    stall = 1'b1;
    step(); check_pf("pend0", 32'h22, 1'b0);
    br_taken = 1'b1; br_target = 32'h50;
    step();
    br_taken = 1'b0; jmp_valid = 1'b1; jmp_target = 32'h60;
    step(); check_pf("pend1", 32'h22, 1'b0);
    jmp_valid = 1'b0; stall = 1'b0;
    step(); check_pf("pend_apply", 32'h50, 1'b1);
    step(); step(); check_pf("pend_done", 32'h52, 1'b0);

    // stall inside flush freezes pc and counter
    jmp_valid = 1'b1; jmp_target = 32'h100;
    step(); check_pf("fst0", 32'h100, 1'b1);
    jmp_valid = 1'b0; stall = 1'b1;
    step(); check_pf("fst1", 32'h100, 1'b1);
    stall = 1'b0;
    step(); check_pf("fst2", 32'h101, 1'b1);
    step(); check_pf("fst3", 32'h102, 1'b0);

    // wrap at 0xFFFF_FFFF
    jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFF;
    step(); check_pf("wrap0", 32'hFFFF_FFFF, 1'b1);
    check("wrap_plus1", pc_plus1, 32'd0);
    jmp_valid = 1'b0;
    step(); check_pf("wrap1", 32'd0, 1'b1);
    step(); check_pf("wrap2", 32'd1, 1'b0);

    // halt freezes pc, ignores redirects, reset recovers
    halt = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      br_taken = (i == 4); br_target = 32'h700;
      check_pf("halt", 32'd1, 1'b0);
      check("halt_fv", {31'd0, fetch_valid}, 32'd0);
      step();
    end
    br_taken = 1'b0;
    check_pf("halt_end", 32'd1, 1'b0);
    reset = 1'b1;
    step(); check_pf("hrst", 32'd0, 1'b0);
    reset = 1'b0;
    step(); check_pf("hrst1", 32'd0, 1'b0);
    check("hrst1_fv", {31'd0, fetch_valid}, 32'd1);
    step(); check_pf("hrst2", 32'd1, 1'b0);

    // reset in the middle of a flush window
    jmp_valid = 1'b1; jmp_target = 32'h200;
    step(); check_pf("mf0", 32'h200, 1'b1);
    jmp_valid = 1'b0; reset = 1'b1;
    step(); check_pf("mf_rst", 32'd0, 1'b0);
    reset = 1'b0;
    step();

`ifdef PC_EXCEPTION_EN
    // exception during stall
    jmp_valid = 1'b1; jmp_target = 32'h31;
    step(); jmp_valid = 1'b0;
    step(); step(); check_pf("exc_pre", 32'h33, 1'b0);
    stall = 1'b1;
    step(); check_pf("exc_st", 32'h33, 1'b0);
    exc = 1'b1;
    step(); check_pf("exc", 32'h400, 1'b1);
    check("exc_epc", epc, 32'h33);
    exc = 1'b0; stall = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
